mult16_seq_ctrl: RTL and testbench
==================================

Name: mult16_seq_ctrl

Overview:
Sequencing controller that computes a 16x16 unsigned product using one shared 8x8 multiplier, by issuing four 8x8 partial products in turn.
- The 8x8 multiplier sits outside this block and connects through the mul_a, mul_b and mul_prod ports.
- The block shifts each partial product and accumulates it into a 32-bit result.
- Operands enter and the result leaves through valid/ready handshakes.

Parameters:
MUL_LAT, 0, multiplier latency in cycles. 0 = combinational, so mul_prod is sampled in the same cycle the operands are issued. 1 = mul_prod is sampled one cycle after issue. Only 0 and 1 are legal.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
in_a  input  16  multiplicand, unsigned
in_b  input  16  multiplier, unsigned
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_prod  output  32  in_a*in_b
mul_a  output  8  operand to shared 8x8 multiplier
mul_b  output  8  operand to shared 8x8 multiplier
mul_prod  input  16  product returned by 8x8 multiplier
busy  output  1  a transaction is in flight (states MUL0..MUL3)

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - state=IDLE; out_valid=0; out_prod=0; mul_a=0; mul_b=0; busy=0.
  - Accumulator and operand registers are cleared.
  - in_ready=1 after reset.
- States: IDLE -> MUL0 -> MUL1 -> MUL2 -> MUL3 -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a and in_b, clear the accumulator, go to MUL0.
- Step schedule (step: mul_a, mul_b, shift):
  - MUL0: a[7:0], b[7:0], shift 0.
  - MUL1: a[7:0], b[15:8], shift 8.
  - MUL2: a[15:8], b[7:0], shift 8.
  - MUL3: a[15:8], b[15:8], shift 16.
- Accumulation: acc <= acc + ({16'b0, mul_prod} << shift), computed at 32 bits. No overflow is possible, since 65535^2 < 2^32.
- MUL_LAT=0: each MULk state lasts 1 cycle. mul_prod is sampled at the end of that cycle.
- MUL_LAT=1:
  - Each MULk state lasts 2 cycles: an issue cycle, then a capture cycle.
  - mul_a and mul_b are held stable across both cycles.
  - mul_prod is sampled at the end of the capture cycle.
- Latency: the operand handshake completes at edge T.
  - out_valid rises at edge T+4 when MUL_LAT=0.
  - out_valid rises at edge T+8 when MUL_LAT=1.
- Register updates on leaving MUL3: out_prod <= final acc and out_valid <= 1. Both outputs are registers.
- DONE:
  - out_valid=1; out_prod is held stable until out_valid&&out_ready.
  - On that handshake: out_valid<=0, go to IDLE.
  - out_prod keeps its last value; it is meaningful only while out_valid=1.
- in_ready=0 in every state except IDLE. in_valid is ignored outside IDLE. The input handshake cannot overlap with DONE.
- Throughput: one result per 6 cycles minimum (MUL_LAT=0, out_ready held high).
- mul_a and mul_b are driven 0 in IDLE and DONE, which keeps the shared multiplier inputs quiet.
- in_a and in_b may change freely after acceptance; only the latched copies are used.
- Reset mid-operation: the transaction is aborted and discarded with no out_valid pulse. All outputs go to their reset values immediately.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Basic product, MUL_LAT=0, in_a=0x0003, in_b=0x0005, out_ready=1:
  - mul_a/mul_b sequence is (03,05), (03,00), (00,05), (00,00).
  - out_prod=0x0000000F, out_valid at T+4, single-cycle pulse.
- Maximum operands, in_a=0xFFFF, in_b=0xFFFF:
  - out_prod=0xFFFE0001, with no overflow or truncation.
- Backpressure, in_a=0x1234, in_b=0x5678, out_ready=0 for 10 cycles:
  - out_prod=0x06260060 holds stable and out_valid stays 1.
  - in_ready stays 0 and a concurrent in_valid is ignored.
  - After out_ready=1 for one cycle, the controller returns to IDLE with in_ready=1.
- Back-to-back, in_valid held high with two operand sets (0x0010*0x0010, then 0x00FF*0x0101) and out_ready=1:
  - Results are 0x00000100, then 0x0000FFFF.
  - The second accept occurs the cycle after the first output handshake (6-cycle spacing).
- Reset during MUL2, rst_n low for 2 cycles:
  - All outputs return to reset values asynchronously and no out_valid appears.
  - A following 0x0002*0x0003 returns 0x00000006.
- MUL_LAT=1, in_a=0xABCD, in_b=0x0100:
  - Each mul_a/mul_b pair is held for 2 cycles.
  - out_prod=0x00ABCD00, with out_valid at T+8.

Source files
------------

// File: rtl/mult16_seq_ctrl_if.sv
// Operand/result handshake and shared 8x8 multiplier connection for mult16_seq_ctrl.
interface mult16_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_prod;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_prod;
  logic        busy;

  // Environment side: supplies operands, takes results, hosts the multiplier.
  modport master (
    output in_valid, in_a, in_b, out_ready, mul_prod,
    input  in_ready, out_valid, out_prod, mul_a, mul_b, busy
  );

  // Controller side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_prod,
    output in_ready, out_valid, out_prod, mul_a, mul_b, busy
  );
endinterface

// File: rtl/mult16_seq_ctrl.sv
// 16x16 unsigned multiply sequenced over one shared external 8x8 multiplier,
// four shifted partial products accumulated into a 32-bit result.
module mult16_seq_ctrl #(
  parameter int unsigned MUL_LAT = 0
) (
  input logic             clk,
  input logic             rst_n,
  mult16_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, DONE} state_t;

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] acc;
  logic        phase;
  logic        sample;
  logic [31:0] term;

  // With a registered multiplier the first cycle of each step only issues.
  always_comb begin
    sample = (MUL_LAT == 0) ? 1'b1 : phase;
  end

  always_comb begin
    term = '0;
    case (state)
      MUL0:       term = {16'b0, bus.mul_prod};
      MUL1, MUL2: term = {16'b0, bus.mul_prod} << 8;
      MUL3:       term = {16'b0, bus.mul_prod} << 16;
      default:    term = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      acc           <= '0;
      phase         <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_prod  <= '0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            a_q          <= bus.in_a;
            b_q          <= bus.in_b;
            acc          <= '0;
            phase        <= 1'b0;
            bus.mul_a    <= bus.in_a[7:0];
            bus.mul_b    <= bus.in_b[7:0];
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= MUL0;
          end
        end
        MUL0, MUL1, MUL2, MUL3: begin
          if (!sample) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            acc   <= acc + term;
            case (state)
              MUL0: begin
                bus.mul_a <= a_q[7:0];
                bus.mul_b <= b_q[15:8];
                state     <= MUL1;
              end
              MUL1: begin
                bus.mul_a <= a_q[15:8];
                bus.mul_b <= b_q[7:0];
                state     <= MUL2;
              end
              MUL2: begin
                bus.mul_a <= a_q[15:8];
                bus.mul_b <= b_q[15:8];
                state     <= MUL3;
              end
              default: begin
                bus.out_prod  <= acc + term;
                bus.out_valid <= 1'b1;
                bus.mul_a     <= '0;
                bus.mul_b     <= '0;
                bus.busy      <= 1'b0;
                state         <= DONE;
              end
            endcase
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Directed bench for mult16_seq_ctrl with combinational (MUL_LAT=0) and
// registered (MUL_LAT=1) multiplier models.
module tb_mult16_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mult16_seq_ctrl_if bus0 ();
  mult16_seq_ctrl_if bus1 ();

  mult16_seq_ctrl #(.MUL_LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  mult16_seq_ctrl #(.MUL_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  assign bus0.mul_prod = bus0.mul_a * bus0.mul_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus1.mul_prod <= '0;
    else        bus1.mul_prod <= bus1.mul_a * bus1.mul_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction on dut0 with out_ready high: latency and product.
  task automatic run0(input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input string tag);
    int lat;
    bus0.in_valid = 1'b1;
    bus0.in_a = a;
    bus0.in_b = b;
    step();
    bus0.in_valid = 1'b0;
    lat = 0;
    while (!bus0.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_prod"}, bus0.out_prod, exp);
    step();
    chk({tag, "_vld_drop"}, 32'(bus0.out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(bus0.in_ready), 32'd1);
  endtask

  logic [31:0] held;
  int          lat;
  int          seen;
  logic [7:0]  exp_a1 [4];
  logic [7:0]  exp_b1 [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_in_ready",  32'(bus0.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_out_prod",  bus0.out_prod, 32'd0);
    chk("rst_mul_a",     32'(bus0.mul_a), 32'd0);
    chk("rst_mul_b",     32'(bus0.mul_b), 32'd0);
    chk("rst_busy",      32'(bus0.busy), 32'd0);
    chk("rst1_in_ready", 32'(bus1.in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Basic product with operand sequence
    bus0.in_valid = 1'b1; bus0.in_a = 16'h0003; bus0.in_b = 16'h0005;
    step();
    bus0.in_valid = 1'b0; bus0.in_a = 16'hDEAD; bus0.in_b = 16'hBEEF;
    chk("b_busy",   32'(bus0.busy), 32'd1);
    chk("b_ready0", 32'(bus0.in_ready), 32'd0);
    chk("b_s0",     32'({bus0.mul_a, bus0.mul_b}), 32'h0305);
    step();
    chk("b_s1",     32'({bus0.mul_a, bus0.mul_b}), 32'h0300);
    step();
    chk("b_s2",     32'({bus0.mul_a, bus0.mul_b}), 32'h0005);
    step();
    chk("b_s3",     32'({bus0.mul_a, bus0.mul_b}), 32'h0000);
    chk("b_nv3",    32'(bus0.out_valid), 32'd0);
    step();
    chk("b_valid",  32'(bus0.out_valid), 32'd1);
    chk("b_prod",   bus0.out_prod, 32'h0000000F);
    chk("b_idle_mul", 32'({bus0.mul_a, bus0.mul_b}), 32'h0000);
    chk("b_busy_off", 32'(bus0.busy), 32'd0);
    step();
    chk("b_pulse",  32'(bus0.out_valid), 32'd0);
    chk("b_ready1", 32'(bus0.in_ready), 32'd1);

    // Maximum operands
    run0(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "max");

    // Backpressure
    bus0.out_ready = 1'b0;
    bus0.in_valid = 1'b1; bus0.in_a = 16'h1234; bus0.in_b = 16'h5678;
    step();
    bus0.in_a = 16'h0007; bus0.in_b = 16'h0009;
    lat = 0;
    while (!bus0.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("bp_lat",  32'(lat), 32'd4);
    chk("bp_prod", bus0.out_prod, 32'h06260060);
    held = bus0.out_prod;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", 32'(bus0.out_valid), 32'd1);
      chk("bp_hold_prod",  bus0.out_prod, 32'h06260060);
      chk("bp_hold_rdy",   32'(bus0.in_ready), 32'd0);
    end
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(bus0.out_valid), 32'd0);
    chk("bp_release_rdy",   32'(bus0.in_ready), 32'd1);
    chk("bp_prod_kept",     bus0.out_prod, held);
    step();
    chk("bp_no_accept", 32'(bus0.busy), 32'd0);

    // Back-to-back with in_valid held high
    bus0.in_valid = 1'b1; bus0.in_a = 16'h0010; bus0.in_b = 16'h0010;
    step();
    bus0.in_a = 16'h00FF; bus0.in_b = 16'h0101;
    lat = 0;
    while (!bus0.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("bb1_lat",  32'(lat), 32'd4);
    chk("bb1_prod", bus0.out_prod, 32'h00000100);
    step();
    chk("bb1_idle", 32'(bus0.in_ready), 32'd1);
    step();
    chk("bb2_accept_busy", 32'(bus0.busy), 32'd1);
    chk("bb2_accept_mul",  32'({bus0.mul_a, bus0.mul_b}), 32'hFF01);
    bus0.in_valid = 1'b0;
    lat = 0;
    while (!bus0.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("bb2_lat",  32'(lat), 32'd4);
    chk("bb2_prod", bus0.out_prod, 32'h0000FFFF);
    step();

    // Reset during MUL2
    bus0.in_valid = 1'b1; bus0.in_a = 16'h1234; bus0.in_b = 16'h5678;
    step();
    bus0.in_valid = 1'b0;
    step();
    step();
    chk("rm_in_mul2", 32'({bus0.mul_a, bus0.mul_b}), 32'h1278);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_async_mul",   32'({bus0.mul_a, bus0.mul_b}), 32'h0000);
    chk("rm_async_busy",  32'(bus0.busy), 32'd0);
    chk("rm_async_rdy",   32'(bus0.in_ready), 32'd1);
    chk("rm_async_valid", 32'(bus0.out_valid), 32'd0);
    chk("rm_async_prod",  bus0.out_prod, 32'd0);
    seen = 0;
    step();
    if (bus0.out_valid) seen++;
    step();
    if (bus0.out_valid) seen++;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus0.out_valid) seen++;
    end
    chk("rm_no_valid", 32'(seen), 32'd0);
    run0(16'h0002, 16'h0003, 32'h00000006, "rm_after");

    // MUL_LAT=1 instance
    exp_a1[0] = 8'hCD; exp_b1[0] = 8'h00;
    exp_a1[1] = 8'hCD; exp_b1[1] = 8'h01;
    exp_a1[2] = 8'hAB; exp_b1[2] = 8'h00;
    exp_a1[3] = 8'hAB; exp_b1[3] = 8'h01;
    bus1.in_valid = 1'b1; bus1.in_a = 16'hABCD; bus1.in_b = 16'h0100;
    step();
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0;
    for (int i = 0; i < 8; i++) begin
      chk("l1_mul", 32'({bus1.mul_a, bus1.mul_b}), 32'({exp_a1[i/2], exp_b1[i/2]}));
      chk("l1_nv",  32'(bus1.out_valid), 32'd0);
      step();
    end
    chk("l1_valid", 32'(bus1.out_valid), 32'd1);
    chk("l1_prod",  bus1.out_prod, 32'h00ABCD00);
    step();
    chk("l1_pulse", 32'(bus1.out_valid), 32'd0);
    chk("l1_rdy",   32'(bus1.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
